// File: rtl/xosera_bus_host.sv
// Host-side initiator for the Xosera 8-bit register bus.
// Turns word-level register requests into even-then-odd byte bus cycles with
// programmable setup/strobe/hold timing and returns the assembled read word.
module xosera_bus_host #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [1:0]  req_bytes_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        busy_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  localparam int MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
  localparam int CW     = $clog2(MAX_P) + 1;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    odd_byte_q;     // odd (low) write byte, sent after the even one
  logic          odd_pending_q;  // odd byte enabled for this request
  logic [15:0]   rd_word_q;      // read word being assembled

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Transaction sequencer: phase timing, registered bus outputs and response.
  // NOTE: non-blocking assignments only, so every branch sees the pre-edge
  // values of state, cnt and the bus registers regardless of statement order.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      odd_byte_q    <= '0;
      odd_pending_q <= 1'b0;
      rd_word_q     <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= '0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= '0;
      bus_data_oe_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            odd_byte_q    <= req_data_i[7:0];
            odd_pending_q <= req_bytes_i[0];
            rd_word_q     <= '0;
            if (req_bytes_i == 2'b00) begin
              // Nothing to transfer: complete immediately with a zero word.
              state       <= DONE;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= '0;
            end else begin
              // First enabled byte: even if enabled, otherwise odd.
              state         <= SETUP;
              cnt           <= SETUP_LD;
              bus_rd_nwr_o  <= req_rd_nwr_i;
              bus_reg_num_o <= req_reg_num_i;
              bus_bytesel_o <= ~req_bytes_i[1];
              bus_data_o    <= req_bytes_i[1] ? req_data_i[15:8] : req_data_i[7:0];
              bus_data_oe_o <= ~req_rd_nwr_i;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state      <= STROBE;
            cnt        <= STROBE_LD;
            bus_cs_n_o <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state      <= HOLD;
            cnt        <= HOLD_LD;
            bus_cs_n_o <= 1'b1;
            // Read data has had the whole strobe to settle; take it now.
            if (bus_rd_nwr_o) begin
              if (bus_bytesel_o) rd_word_q[7:0]  <= bus_data_i;
              else               rd_word_q[15:8] <= bus_data_i;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (!bus_bytesel_o && odd_pending_q) begin
              state         <= SETUP;
              cnt           <= SETUP_LD;
              bus_bytesel_o <= 1'b1;
              bus_data_o    <= odd_byte_q;
            end else begin
              state         <= DONE;
              rsp_valid_o   <= 1'b1;
              rsp_data_o    <= rd_word_q;
              bus_data_oe_o <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xosera_bus_host.sv
// Self-checking bench for xosera_bus_host: directed cases plus random requests,
// checked cycle by cycle against a timing model derived from phase arithmetic
// and a register-file model answering bus reads.
module tb_xosera_bus_host;

  localparam int S = 1;
  localparam int T = 4;
  localparam int H = 1;
  localparam int B = S + T + H;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_rd_nwr_i;
  logic [3:0]  req_reg_num_i;
  logic [1:0]  req_bytes_i;
  logic [15:0] req_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        busy_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic [3:0]  bus_reg_num_o;
  logic        bus_bytesel_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic [7:0]  bus_data_i;

  int n_checks = 0;
  int n_fails  = 0;

  // Register file seen by reads: index {reg_num, bytesel}.
  logic [7:0]  regs [32];
  logic [15:0] last_rsp = 16'h0000;

  xosera_bus_host #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(T),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_rd_nwr_i (req_rd_nwr_i),
    .req_reg_num_i(req_reg_num_i),
    .req_bytes_i  (req_bytes_i),
    .req_data_i   (req_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o),
    .bus_cs_n_o   (bus_cs_n_o),
    .bus_rd_nwr_o (bus_rd_nwr_o),
    .bus_reg_num_o(bus_reg_num_o),
    .bus_bytesel_o(bus_bytesel_o),
    .bus_data_o   (bus_data_o),
    .bus_data_oe_o(bus_data_oe_o),
    .bus_data_i   (bus_data_i)
  );

  always #5 clk = ~clk;

  assign bus_data_i = regs[{bus_reg_num_o, bus_bytesel_o}];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_cs_n", bus_cs_n_o, 1);
    check("rst_rd_nwr", bus_rd_nwr_o, 1);
    check("rst_reg_num", bus_reg_num_o, 0);
    check("rst_bytesel", bus_bytesel_o, 0);
    check("rst_data_o", bus_data_o, 0);
    check("rst_oe", bus_data_oe_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", req_ready_o, 1);
  endtask

  // Runs one request. Called at a negedge with the DUT idle; returns at the
  // negedge of the first idle cycle after DONE (cycle 2 + n*B).
  task automatic run_txn(input logic rd, input logic [3:0] rn, input logic [1:0] be,
                         input logic [15:0] wd, input bit hold_valid);
    int          n;
    logic        sel [2];
    logic [15:0] exp_word;
    req_valid_i   = 1'b1;
    req_rd_nwr_i  = rd;
    req_reg_num_i = rn;
    req_bytes_i   = be;
    req_data_i    = wd;
    check("ready_at_accept", req_ready_o, 1);
    check("busy_at_accept", busy_o, 0);
    n = 0;
    if (be[1]) begin sel[n] = 1'b0; n++; end
    if (be[0]) begin sel[n] = 1'b1; n++; end
    exp_word = 16'h0000;
    if (rd && be[1]) exp_word[15:8] = regs[{rn, 1'b0}];
    if (rd && be[0]) exp_word[7:0]  = regs[{rn, 1'b1}];
    @(posedge clk);  // accept edge: cycle 0
    for (int k = 1; k <= n * B + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !hold_valid) req_valid_i = 1'b0;
      check("ready_busy_phase", req_ready_o, 0);
      check("busy", busy_o, 1);
      if (k <= n * B) begin
        int  idx = (k - 1) / B;
        int  off = (k - 1) % B;
        bit  strobe = (off >= S) && (off < S + T);
        check("cs_n", bus_cs_n_o, strobe ? 0 : 1);
        check("bytesel", bus_bytesel_o, sel[idx]);
        check("reg_num", bus_reg_num_o, rn);
        check("rd_nwr", bus_rd_nwr_o, rd);
        check("oe", bus_data_oe_o, rd ? 0 : 1);
        if (!rd) check("data_o", bus_data_o, sel[idx] ? wd[7:0] : wd[15:8]);
        check("rsp_valid_idle", rsp_valid_o, 0);
      end else begin
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_data", rsp_data_o, exp_word);
        check("cs_n_done", bus_cs_n_o, 1);
        check("oe_done", bus_data_oe_o, 0);
      end
    end
    last_rsp = exp_word;
    @(negedge clk);
    check("rsp_valid_pulse", rsp_valid_o, 0);
    check("ready_after", req_ready_o, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 8'($urandom);
    regs[{4'hB, 1'b0}] = 8'hAB;
    regs[{4'hB, 1'b1}] = 8'hCD;

    reset_n_i     = 1'b0;
    req_valid_i   = 1'b0;
    req_rd_nwr_i  = 1'b0;
    req_reg_num_i = 4'h0;
    req_bytes_i   = 2'b00;
    req_data_i    = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset_n_i = 1'b1;
    @(negedge clk);

    // Directed cases from the test plan.
    run_txn(1'b0, 4'h8, 2'b11, 16'h1234, 1'b0);  // word write
    run_txn(1'b1, 4'hB, 2'b11, 16'h0000, 1'b0);  // word read -> 0xABCD
    run_txn(1'b0, 4'h0, 2'b01, 16'h000F, 1'b0);  // odd-only write
    run_txn(1'b0, 4'h3, 2'b00, 16'hFFFF, 1'b0);  // zero bytes
    run_txn(1'b1, 4'hB, 2'b10, 16'h0000, 1'b0);  // even-only read
    // Back-to-back with valid held high: second accept at cycle 2 + 2*B.
    run_txn(1'b0, 4'h5, 2'b11, 16'hA55A, 1'b1);
    run_txn(1'b0, 4'h5, 2'b11, 16'hA55A, 1'b0);

    // Reset during the first strobe of a word write.
    req_valid_i   = 1'b1;
    req_rd_nwr_i  = 1'b0;
    req_reg_num_i = 4'h8;
    req_bytes_i   = 2'b11;
    req_data_i    = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    check("cs_n_strobe_pre_reset", bus_cs_n_o, 0);
    #1 reset_n_i = 1'b0;
    #1 check("cs_n_async_rise", bus_cs_n_o, 1);
    @(negedge clk);
    check_reset_values();
    reset_n_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("no_rsp_after_abort", rsp_valid_o, 0);
    end
    run_txn(1'b0, 4'h8, 2'b11, 16'h1234, 1'b0);

    // Random requests with random idle gaps; the response must hold in gaps.
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), 4'($urandom), 2'($urandom), 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rsp_hold", rsp_data_o, last_rsp);
        check("idle_cs_n", bus_cs_n_o, 1);
        check("idle_oe", bus_data_oe_o, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
